// File: rtl/rr_mux4_stream.sv
// Four-input round-robin stream mux: merges four valid/ready sources onto one tagged output.
// Latency: 1 cycle from a source handshake (d_valid & d_ready) to y_valid; 1 word/cycle sustained.
// Backpressure: y_ready low with y_valid high freezes y/y_sel/y_valid and the pointer; d_ready is 0000.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   d_valid, d_ready  per-source handshake, bit i belongs to source i
//   d                 packed source words, source i at [i*DATA_W +: DATA_W]
//   y_valid, y_ready  output handshake (y_valid registered)
//   y, y_sel          registered output word and its 2-bit source index
module rr_mux4_stream #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          d_valid,
  output logic [3:0]          d_ready,
  input  logic [4*DATA_W-1:0] d,
  output logic                y_valid,
  input  logic                y_ready,
  output logic [DATA_W-1:0]   y,
  output logic [1:0]          y_sel
);

  logic [1:0]        ptr;
  logic [3:0]        grant;
  logic [1:0]        win;
  logic [1:0]        idx;
  logic              found;
  logic              load_en;
  logic [DATA_W-1:0] win_dat;

  // The output slot can be refilled in the same cycle it drains, which is
  // what gives full throughput with y_ready held high.
  assign load_en = (|d_valid) && (!y_valid || y_ready);

  // Scan ptr, ptr+1, ptr+2, ptr+3 (2-bit wrap); first requester wins.
  always_comb begin
    grant = 4'b0000;
    win   = ptr;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && d_valid[idx]) begin
        found      = 1'b1;
        win        = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  assign win_dat = d[win*DATA_W +: DATA_W];

  // Gated by rst so no source sees an accept while the block is held in reset.
  assign d_ready = (load_en && !rst) ? grant : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid <= 1'b0;
      y       <= '0;
      y_sel   <= 2'd0;
      ptr     <= 2'd0;
    end else if (load_en) begin
      y       <= win_dat;
      y_sel   <= win;
      y_valid <= 1'b1;
      ptr     <= win + 2'd1;
    end else if (y_ready) begin
      // Drained with nothing to load: data and tag keep their last values.
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux4_stream.sv
module tb_rr_mux4_stream;

  localparam int DATA_W = 8;

  logic                clk;
  logic                rst;
  logic [3:0]          d_valid;
  logic [3:0]          d_ready;
  logic [4*DATA_W-1:0] d;
  logic                y_valid;
  logic                y_ready;
  logic [DATA_W-1:0]   y;
  logic [1:0]          y_sel;

  rr_mux4_stream #(.DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .d       (d),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y       (y),
    .y_sel   (y_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what the output register and the fairness pointer
  // should hold according to the merge rules.
  int        m_vld;
  int        m_y;
  int        m_sel;
  int        m_ptr;
  // Per-source scoreboard of accepted words not yet seen on y.
  int        sb_q [4][$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_y = 0; m_sel = 0; m_ptr = 0;
    for (int i = 0; i < 4; i++) sb_q[i].delete();
  endtask

  function automatic int src_word(input logic [4*DATA_W-1:0] dd, input int i);
    return int'((dd >> (i * DATA_W)) & 32'hFF);
  endfunction

  // One clock: sample at negedge, compare against the model, update the
  // scoreboard, advance the model, return 1ns after the next posedge.
  task automatic cycle();
    int w;
    int exp_rdy;
    bit load;
    @(negedge clk);
    w = -1;
    for (int k = 0; k < 4; k++) begin
      if (w < 0 && d_valid[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
    end
    load    = (w >= 0) && (m_vld == 0 || y_ready);
    exp_rdy = load ? (1 << w) : 0;
    check("d_ready", 32'(d_ready), 32'(exp_rdy));
    check("y_valid", 32'(y_valid), 32'(m_vld));
    if (m_vld != 0) begin
      check("y",     32'(y),     32'(m_y));
      check("y_sel", 32'(y_sel), 32'(m_sel));
    end
    // Conservation / ordering: an output word consumed now must be the
    // oldest outstanding word of its source.
    if (y_valid && y_ready) begin
      if (sb_q[y_sel].size() == 0) check("sb_underrun", 32'(0), 32'(1));
      else check("sb_order", 32'(y), 32'(sb_q[y_sel].pop_front()));
    end
    for (int i = 0; i < 4; i++)
      if (d_valid[i] && d_ready[i]) sb_q[i].push_back(src_word(d, i));
    if (load) begin
      m_y   = src_word(d, w);
      m_sel = w;
      m_vld = 1;
      m_ptr = (w + 1) % 4;
    end else if (y_ready) begin
      m_vld = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    d_valid = 4'b0000;
    d       = '0;
    y_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("rst_y_valid", 32'(y_valid), 32'(0));
    check("rst_y",       32'(y),       32'(0));
    check("rst_y_sel",   32'(y_sel),   32'(0));
    check("rst_d_ready", 32'(d_ready), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Single source: source 2 only.
    d_valid = 4'b0100; d = 32'h00A5_0000; y_ready = 1'b1;
    #1;
    check("single_rdy", 32'(d_ready), 32'(4'b0100));
    cycle();
    d_valid = 4'b0000;
    check("single_y",     32'(y),       32'(8'hA5));
    check("single_sel",   32'(y_sel),   32'(2));
    check("single_valid", 32'(y_valid), 32'(1));

    // Reset while a word is held under backpressure.
    y_ready = 1'b0; d_valid = 4'b1111; d = 32'h1312_1110;
    cycle();
    check("pre_rst_valid", 32'(y_valid), 32'(1));
    #2; rst = 1'b1; #1;
    check("midrst_y_valid", 32'(y_valid), 32'(0));
    check("midrst_y",       32'(y),       32'(0));
    check("midrst_y_sel",   32'(y_sel),   32'(0));
    check("midrst_d_ready", 32'(d_ready), 32'(0));
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // Full rotation from ptr=0 with every source requesting.
    y_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("rot_valid", 32'(y_valid), 32'(1));
      check("rot_sel",   32'(y_sel),   32'(k % 4));
      check("rot_y",     32'(y),       32'(8'h10 + (k % 4)));
    end

    // Backpressure: held word is sel 1 / 0x11.
    y_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_valid", 32'(y_valid), 32'(1));
      check("bp_sel",   32'(y_sel),   32'(1));
      check("bp_y",     32'(y),       32'(8'h11));
      check("bp_rdy",   32'(d_ready), 32'(0));
    end
    y_ready = 1'b1;
    cycle();
    check("bp_resume_sel", 32'(y_sel), 32'(2));

    // Pointer wrap: grant source 1 (ptr->2), then 1001 serves 3 then 0.
    d_valid = 4'b0010;
    cycle();
    check("wrap_pre_sel", 32'(y_sel), 32'(1));
    d_valid = 4'b1001;
    cycle();
    check("wrap_sel3", 32'(y_sel), 32'(3));
    cycle();
    check("wrap_sel0", 32'(y_sel), 32'(0));
    d_valid = 4'b1111;
    cycle();
    check("wrap_ptr1", 32'(y_sel), 32'(1));

    // Drain and reload in the same cycle.
    d_valid = 4'b0001; d = 32'h1312_113C;
    cycle();
    check("dl_valid", 32'(y_valid), 32'(1));
    check("dl_y",     32'(y),       32'(8'h3C));
    check("dl_sel",   32'(y_sel),   32'(0));

    // Randomized traffic against the model and scoreboard.
    for (int n = 0; n < 10000; n++) begin
      d_valid = 4'($urandom_range(0, 15));
      d       = $urandom;
      y_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Drain and confirm nothing was lost.
    d_valid = 4'b0000; y_ready = 1'b1;
    for (int n = 0; n < 3; n++) cycle();
    check("final_valid", 32'(y_valid), 32'(0));
    for (int i = 0; i < 4; i++) check("sb_leftover", 32'(sb_q[i].size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
